// File: rtl/uart_cmd_arbiter.sv
// Round-robin arbiter sharing one UART command engine between NUM_REQ requesters.
// Tracks each command to write release, read return or timeout, and routes completion back.
module uart_cmd_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int CMD_ADDR_WIDTH = 7,
  parameter int CMD_DATA_WIDTH = 8,
  parameter int CMD_WIDTH      = 1 + CMD_ADDR_WIDTH + CMD_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*CMD_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            done,
  output logic                          rsp_err,
  output logic [CMD_DATA_WIDTH-1:0]     rsp_data,
  output logic                          m_cmd_valid,
  output logic [CMD_WIDTH-1:0]          m_cmd_data,
  input  logic                          m_cmd_ready,
  input  logic                          m_read_valid,
  input  logic [CMD_DATA_WIDTH-1:0]     m_read_data,
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_WR, WAIT_RD, DONE} state_t;

  state_t               state;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     gnt;
  logic [CMD_WIDTH-1:0] cmd_buf;
  logic [TW-1:0]        tcnt;
  logic                 seen_busy;

  logic                 found;
  logic [IDX_W-1:0]     win;
  int                   rr_idx;
  logic                 wr_cmp;
  logic                 rd_cmp;
  logic                 tmo;

  // Search upward from ptr+1 so the last winner has the lowest priority.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    rr_idx = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req_valid[rr_idx]) begin
        found = 1'b1;
        win   = IDX_W'(rr_idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && found) req_ready[win] = 1'b1;
  end

  assign m_cmd_valid = (state == ISSUE);
  assign m_cmd_data  = cmd_buf;
  assign busy        = (state != IDLE);

  assign wr_cmp = (state == WAIT_WR) && seen_busy && m_cmd_ready;
  assign rd_cmp = (state == WAIT_RD) && m_read_valid;
  assign tmo    = ((state == WAIT_WR) || (state == WAIT_RD)) && (tcnt == TMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= IDX_W'(NUM_REQ - 1);
      gnt       <= '0;
      cmd_buf   <= '0;
      tcnt      <= '0;
      seen_busy <= 1'b0;
      done      <= '0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt     <= win;
            ptr     <= win;
            cmd_buf <= req_data[int'(win)*CMD_WIDTH +: CMD_WIDTH];
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_cmd_ready) begin
            tcnt      <= '0;
            seen_busy <= 1'b0;
            state     <= cmd_buf[CMD_WIDTH-1] ? WAIT_WR : WAIT_RD;
          end
        end
        WAIT_WR: begin
          tcnt <= tcnt + TW'(1);
          if (!m_cmd_ready) seen_busy <= 1'b1;
          // Completion takes precedence over a coincident timeout.
          if (wr_cmp || tmo) begin
            rsp_err   <= !wr_cmp;
            rsp_data  <= '0;
            done[gnt] <= 1'b1;
            state     <= DONE;
          end
        end
        WAIT_RD: begin
          tcnt <= tcnt + TW'(1);
          if (rd_cmp) begin
            rsp_err   <= 1'b0;
            rsp_data  <= m_read_data;
            done[gnt] <= 1'b1;
            state     <= DONE;
          end else if (tmo) begin
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            done[gnt] <= 1'b1;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_arbiter.sv
// Directed bench for uart_cmd_arbiter: one instance at default timeout, one with TIMEOUT_CYCLES=50.
module tb_uart_cmd_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;

  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready, done;
  logic        rsp_err, m_cmd_valid, m_cmd_ready, m_read_valid, busy;
  logic [7:0]  rsp_data, m_read_data;
  logic [15:0] m_cmd_data;

  logic [3:0]  t_req_valid;
  logic [63:0] t_req_data;
  logic [3:0]  t_req_ready, t_done;
  logic        t_rsp_err, t_m_cmd_valid, t_m_cmd_ready, t_m_read_valid, t_busy;
  logic [7:0]  t_rsp_data, t_m_read_data;
  logic [15:0] t_m_cmd_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_cmd_arbiter #(.NUM_REQ(4), .CMD_ADDR_WIDTH(7), .CMD_DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .done(done), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .m_cmd_valid(m_cmd_valid), .m_cmd_data(m_cmd_data), .m_cmd_ready(m_cmd_ready),
    .m_read_valid(m_read_valid), .m_read_data(m_read_data), .busy(busy)
  );

  uart_cmd_arbiter #(.NUM_REQ(4), .CMD_ADDR_WIDTH(7), .CMD_DATA_WIDTH(8),
                     .TIMEOUT_CYCLES(50)) dut_t (
    .clk(clk), .rst_n(rst_n), .req_valid(t_req_valid), .req_data(t_req_data),
    .req_ready(t_req_ready), .done(t_done), .rsp_err(t_rsp_err), .rsp_data(t_rsp_data),
    .m_cmd_valid(t_m_cmd_valid), .m_cmd_data(t_m_cmd_data), .m_cmd_ready(t_m_cmd_ready),
    .m_read_valid(t_m_read_valid), .m_read_data(t_m_read_data), .busy(t_busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Runs one read from the IDLE negedge (req_valid already driven) and captures observations.
  task automatic run_read(input logic [7:0] rdata, output logic [3:0] rr,
                          output logic [15:0] cmd, output logic [3:0] dn, output logic [7:0] rd);
    #1 rr = req_ready;
    @(negedge clk); cmd = m_cmd_data; m_cmd_ready = 1'b1;
    @(negedge clk); m_read_valid = 1'b1; m_read_data = rdata;
    @(negedge clk); m_read_valid = 1'b0; dn = done; rd = rsp_data;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; m_cmd_ready = 1'b1;
    @(negedge clk); #1;
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL reset_req_ready got=%h exp=0", req_ready); end
    total++; if (done !== 4'h0) begin bad++; $display("FAIL reset_done got=%h exp=0", done); end
    total++; if (m_cmd_valid !== 1'b0 || m_cmd_data !== 16'h0) begin bad++;
      $display("FAIL reset_cmd got=%b/%h exp=0/0000", m_cmd_valid, m_cmd_data); end
    total++; if (busy !== 1'b0 || rsp_err !== 1'b0 || rsp_data !== 8'h0) begin bad++;
      $display("FAIL reset_misc busy=%b err=%b data=%h exp=0/0/00", busy, rsp_err, rsp_data); end
    req_valid = 4'h0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    req_data[31:16] = 16'h1200; req_valid = 4'b0010; m_cmd_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL read_accept got=%b exp=0010", req_ready); end
    @(negedge clk); req_valid = 4'h0; req_data[31:16] = 16'hFFFF;
    total++; if (m_cmd_valid !== 1'b1 || m_cmd_data !== 16'h1200) begin bad++;
      $display("FAIL read_issue got=%b/%h exp=1/1200", m_cmd_valid, m_cmd_data); end
    @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      total++; if (done !== 4'h0) begin bad++; $display("FAIL read_early_done cyc=%0d got=%b exp=0000", i, done); end
      @(negedge clk);
    end
    m_read_valid = 1'b1; m_read_data = 8'hA5;
    @(negedge clk); m_read_valid = 1'b0;
    total++; if (done !== 4'b0010 || rsp_data !== 8'hA5 || rsp_err !== 1'b0) begin bad++;
      $display("FAIL read_done got=%b/%h/%b exp=0010/a5/0", done, rsp_data, rsp_err); end
    @(negedge clk);
    total++; if (done !== 4'h0 || busy !== 1'b0) begin bad++;
      $display("FAIL read_pulse_width done=%b busy=%b exp=0000/0", done, busy); end
  endtask

  task automatic test_write();
    req_data[15:0] = 16'h8A55; req_valid = 4'b0001; m_cmd_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL write_accept got=%b exp=0001", req_ready); end
    @(negedge clk); req_valid = 4'h0;
    total++; if (m_cmd_valid !== 1'b1 || m_cmd_data !== 16'h8A55) begin bad++;
      $display("FAIL write_issue got=%b/%h exp=1/8a55", m_cmd_valid, m_cmd_data); end
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      total++; if (done !== 4'h0 || m_cmd_valid !== 1'b0) begin bad++;
        $display("FAIL write_wait cyc=%0d done=%b valid=%b exp=0000/0", i, done, m_cmd_valid); end
      m_cmd_ready = 1'b0;
      @(negedge clk);
    end
    total++; if (done !== 4'h0) begin bad++; $display("FAIL write_early_done got=%b exp=0000", done); end
    m_cmd_ready = 1'b1;
    @(negedge clk);
    total++; if (done !== 4'b0001 || rsp_err !== 1'b0 || rsp_data !== 8'h00) begin bad++;
      $display("FAIL write_done got=%b/%b/%h exp=0001/0/00", done, rsp_err, rsp_data); end
    @(negedge clk);
    total++; if (done !== 4'h0) begin bad++; $display("FAIL write_pulse_width got=%b exp=0000", done); end
  endtask

  task automatic test_simultaneous();
    logic [3:0] rr, dn; logic [15:0] cmd; logic [7:0] rd;
    do_reset();
    req_data[15:0] = 16'h0111; req_data[47:32] = 16'h0333; req_valid = 4'b0101;
    run_read(8'h11, rr, cmd, dn, rd);
    total++; if (rr !== 4'b0001 || cmd !== 16'h0111 || dn !== 4'b0001 || rd !== 8'h11) begin bad++;
      $display("FAIL simul_first rr=%b cmd=%h done=%b data=%h exp=0001/0111/0001/11", rr, cmd, dn, rd); end
    run_read(8'h33, rr, cmd, dn, rd);
    total++; if (rr !== 4'b0100 || cmd !== 16'h0333 || dn !== 4'b0100 || rd !== 8'h33) begin bad++;
      $display("FAIL simul_second rr=%b cmd=%h done=%b data=%h exp=0100/0333/0100/33", rr, cmd, dn, rd); end
    req_valid = 4'h0;
  endtask

  task automatic test_round_robin();
    logic [3:0] rr, dn; logic [15:0] cmd; logic [7:0] rd;
    logic [3:0] exp_rr [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [15:0] exp_cmd [5] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0100};
    do_reset();
    req_data = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    req_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      run_read(8'(n + 8'h40), rr, cmd, dn, rd);
      total++; if (rr !== exp_rr[n] || cmd !== exp_cmd[n] || dn !== exp_rr[n] || rd !== 8'(n + 8'h40)) begin bad++;
        $display("FAIL rr_grant%0d rr=%b cmd=%h done=%b data=%h exp=%b/%h/%b/%h",
                 n, rr, cmd, dn, rd, exp_rr[n], exp_cmd[n], exp_rr[n], 8'(n + 8'h40)); end
    end
    req_valid = 4'h0;
  endtask

  task automatic test_timeout();
    int n;
    t_req_data = {16'h3300, 16'h0, 16'h0, 16'h0};
    t_req_valid = 4'b1000; t_m_cmd_ready = 1'b1;
    #1;
    total++; if (t_req_ready !== 4'b1000) begin bad++; $display("FAIL tmo_accept got=%b exp=1000", t_req_ready); end
    @(negedge clk); t_req_valid = 4'h0;
    // Successful read first so the timeout must actively clear rsp_data.
    @(negedge clk); t_m_read_valid = 1'b1; t_m_read_data = 8'h5A;
    @(negedge clk); t_m_read_valid = 1'b0;
    total++; if (t_done !== 4'b1000 || t_rsp_data !== 8'h5A) begin bad++;
      $display("FAIL tmo_preread got=%b/%h exp=1000/5a", t_done, t_rsp_data); end
    @(negedge clk); t_req_valid = 4'b1000;
    @(negedge clk); t_req_valid = 4'h0;
    @(negedge clk);
    n = 0;
    while (t_done === 4'h0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++; if (n !== 50) begin bad++; $display("FAIL tmo_latency got=%0d exp=50", n); end
    total++; if (t_done !== 4'b1000 || t_rsp_err !== 1'b1 || t_rsp_data !== 8'h00) begin bad++;
      $display("FAIL tmo_done got=%b/%b/%h exp=1000/1/00", t_done, t_rsp_err, t_rsp_data); end
    @(negedge clk);
    t_m_read_valid = 1'b1; t_m_read_data = 8'hEE;
    @(negedge clk);
    @(negedge clk); t_m_read_valid = 1'b0;
    total++; if (t_done !== 4'h0 || t_busy !== 1'b0 || t_rsp_data !== 8'h00 || t_rsp_err !== 1'b1) begin bad++;
      $display("FAIL tmo_late_read done=%b busy=%b data=%h err=%b exp=0000/0/00/1",
               t_done, t_busy, t_rsp_data, t_rsp_err); end
  endtask

  task automatic test_reset_mid_read();
    logic [3:0] seen;
    seen = 4'h0;
    req_data[15:0] = 16'h0A00; req_valid = 4'b0001; m_cmd_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rst_mid_accept got=%b exp=0001", req_ready); end
    @(negedge clk); req_valid = 4'h0;
    repeat (6) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_mid_waiting busy=%b exp=1", busy); end
    rst_n = 1'b0; req_valid = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      #1;
      seen = seen | done;
      total++; if (req_ready !== 4'h0 || m_cmd_valid !== 1'b0 || m_cmd_data !== 16'h0 || busy !== 1'b0 ||
                   rsp_err !== 1'b0 || rsp_data !== 8'h0) begin bad++;
        $display("FAIL rst_mid_outputs rr=%b v=%b d=%h busy=%b err=%b data=%h exp=all zero",
                 req_ready, m_cmd_valid, m_cmd_data, busy, rsp_err, rsp_data); end
      @(negedge clk);
    end
    rst_n = 1'b1; req_valid = 4'h0; m_read_valid = 1'b1; m_read_data = 8'h77;
    @(negedge clk); seen = seen | done;
    @(negedge clk); seen = seen | done; m_read_valid = 1'b0;
    total++; if (seen !== 4'h0 || busy !== 1'b0 || rsp_data !== 8'h00) begin bad++;
      $display("FAIL rst_mid_no_done done=%b busy=%b data=%h exp=0000/0/00", seen, busy, rsp_data); end
    req_valid = 4'b0111;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rst_mid_regrant got=%b exp=0001", req_ready); end
    req_valid = 4'h0;
  endtask

  initial begin
    req_valid = '0; req_data = '0; m_cmd_ready = 1'b1; m_read_valid = 1'b0; m_read_data = '0;
    t_req_valid = '0; t_req_data = '0; t_m_cmd_ready = 1'b1; t_m_read_valid = 1'b0; t_m_read_data = '0;
    rst_n = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_simultaneous();
    test_round_robin();
    test_timeout();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_cmd_arbiter.md
# uart_cmd_arbiter

Round-robin arbiter that shares one UART command engine between NUM_REQ requesters. It accepts one command at a time, presents it on the engine's valid/ready command port, and tracks the transaction to completion: write release, or read-data return. It then routes a completion pulse and any read data back to the requester that owns the transaction. It sits between the register-access clients and the UART command FSM, and provides a response timeout so a lost read can never lock the link.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- CMD_ADDR_WIDTH, 7: command address width.
- CMD_DATA_WIDTH, 8: command and read-data width.
- CMD_WIDTH, 1+CMD_ADDR_WIDTH+CMD_DATA_WIDTH: command word width; MSB is the RW flag (1 = write, 0 = read).
- TIMEOUT_CYCLES, 65535: maximum cycles to wait for completion. Counter width is $clog2(TIMEOUT_CYCLES+1).
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_data  in  NUM_REQ*CMD_WIDTH  command words; requester i occupies slice [i*CMD_WIDTH +: CMD_WIDTH].
- req_ready  out  NUM_REQ  one-hot acceptance strobe.
- done  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_err  out  1  qualified by done; 1 means the transaction timed out.
- rsp_data  out  CMD_DATA_WIDTH  read data, qualified by done on a read.
- m_cmd_valid  out  1  command valid to the UART engine.
- m_cmd_data  out  CMD_WIDTH  command word to the UART engine.
- m_cmd_ready  in  1  UART engine idle/accept.
- m_read_valid  in  1  UART engine read-data strobe.
- m_read_data  in  CMD_DATA_WIDTH  UART engine read data.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT_WR, WAIT_RD, DONE.
- IDLE:
  - If any req_valid is high, select a winner by round-robin, searching upward from ptr+1 modulo NUM_REQ.
  - Assert req_ready[winner] combinationally in the same cycle.
  - Latch the winner index into gnt and its command into cmd_buf; set ptr to the winner; go to ISSUE.
  - With no req_valid, stay in IDLE.
- ISSUE:
  - m_cmd_valid=1 and m_cmd_data=cmd_buf.
  - On m_cmd_ready=1, the handshake completes. Go to WAIT_WR if cmd_buf[CMD_WIDTH-1]=1, otherwise to WAIT_RD.
  - The timeout does not run in ISSUE.
- WAIT_WR:
  - Set the seen_busy flag when m_cmd_ready=0.
  - Complete when seen_busy=1 and m_cmd_ready=1 in the same cycle.
- WAIT_RD:
  - Complete on m_read_valid=1 and capture m_read_data into rsp_data.
  - m_read_valid is ignored in all other states.
- Timeout:
  - tcnt clears on entry to WAIT_WR/WAIT_RD and increments each cycle in those states.
  - When tcnt reaches TIMEOUT_CYCLES-1 without completion: rsp_err=1, rsp_data=0, go to DONE.
  - If completion and timeout occur in the same cycle, completion wins with rsp_err=0.
- DONE: done[gnt]=1 for exactly one cycle, then go to IDLE.
- Write completions report rsp_data=0 and rsp_err=0.
- Fairness: the last-granted requester has the lowest priority in the next arbitration.

## Timing
- Reset values: ptr=NUM_REQ-1 (requester 0 wins first), gnt=0, cmd_buf=0, rsp_data=0, rsp_err=0, tcnt=0, seen_busy=0.
- Output values while rst_n is low: req_ready=0, done=0, m_cmd_valid=0, m_cmd_data=0, busy=0.
- req_ready[i] is high in cycle T; m_cmd_valid rises at T+1.
- The earliest m_cmd_valid is one cycle after acceptance.
- Completion is detected in cycle C; done is high at C+1; the next req_ready can occur at C+2.
- Minimum write transaction: 1 (IDLE) + 1 (ISSUE) + 2 (WAIT_WR) + 1 (DONE) = 5 cycles.
- m_cmd_valid stays high and m_cmd_data stays stable in ISSUE until m_cmd_ready is seen.
- req_data from non-winners and changes to the winner's req_data after acceptance have no effect.
- Reset mid-transaction: return to IDLE immediately, with no done pulse and no m_cmd_valid. Any engine response that arrives later is ignored.
- done, rsp_data and rsp_err are registered; req_ready, m_cmd_valid and busy decode from the state register.

## Test plan
- Write test:
  - Stimulus: req 0 sends 0x8A55 with m_cmd_ready held 1, dropped for 10 cycles after the handshake, then raised.
  - Required: m_cmd_data=0x8A55, WAIT_WR exits on m_cmd_ready returning to 1, done[0] one cycle, rsp_err=0.
- Read test:
  - Stimulus: req 1 sends 0x1200; the engine returns m_read_valid with 0xA5 after 200 cycles.
  - Required: done[1] pulses with rsp_data=0xA5, rsp_err=0; done[0,2,3] stay 0.
- Simultaneous requests after reset:
  - Stimulus: req 0 and req 2 assert in the same cycle.
  - Required: req_ready[0] first; req 2 is accepted at the next IDLE.
- Round robin:
  - Stimulus: all four requesters assert continuously.
  - Required: grant order 0,1,2,3,0; no requester is starved.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=50; read from req 3 with no m_read_valid.
  - Required: done[3] exactly 50 cycles after WAIT_RD entry, rsp_err=1, rsp_data=0.
  - Stimulus: a late m_read_valid arrives in IDLE.
  - Required: it is ignored.
- Reset mid-read:
  - Stimulus: rst_n low for 3 cycles during WAIT_RD.
  - Required: all outputs are at reset values, there is no done pulse, and the next arbitration grants requester 0 first.
